// File: rtl/fifo_wr_logic_if.sv
// Write-side handshake bundle between the FIFO write logic and its user/memory.
interface fifo_wr_logic_if #(
  parameter int unsigned PTR_SZ = 2
);
  logic              winc;
  logic [PTR_SZ-1:0] rq2_raddr;
  logic              wfull;
  logic              write_en;
  logic [PTR_SZ-1:0] waddr;
  logic [PTR_SZ-1:0] waddr_gray;

  modport master (
    output winc, rq2_raddr,
    input  wfull, write_en, waddr, waddr_gray
  );

  modport slave (
    input  winc, rq2_raddr,
    output wfull, write_en, waddr, waddr_gray
  );
endinterface

// File: rtl/fifo_wr_logic.sv
// Write-side pointer and full-flag controller for a dual-clock FIFO.
// Pointer wraps modulo DEPTH; one slot is kept empty to distinguish full.
module fifo_wr_logic #(
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned PTR_SZ = 2
) (
  input logic            clk,
  input logic            rst,
  fifo_wr_logic_if.slave bus
);

  localparam logic [0:0]        NOT_FULL = 1'b0;
  localparam logic [0:0]        FULL     = 1'b1;
  localparam logic [PTR_SZ-1:0] LAST     = PTR_SZ'(DEPTH - 1);

  logic [0:0]        current_state;
  logic [0:0]        next_state;
  logic [PTR_SZ-1:0] waddr;
  logic [PTR_SZ-1:0] waddr_gray;
  logic [PTR_SZ-1:0] waddr_tmp;
  logic [PTR_SZ-1:0] raddr;
  logic              wfull;
  logic              write_en;
  logic              wfull_tmp;

  function automatic logic [PTR_SZ-1:0] inc(input logic [PTR_SZ-1:0] p);
    return (p == LAST) ? '0 : p + PTR_SZ'(1);
  endfunction

  // Gray to binary: each bit is the XOR of itself and all higher Gray bits
  always_comb begin
    raddr = '0;
    for (int i = 0; i < int'(PTR_SZ); i++) begin
      raddr[i] = ^(bus.rq2_raddr >> i);
    end
  end

  assign wfull     = (current_state == FULL);
  assign write_en  = rst & bus.winc & ~wfull;
  assign waddr_tmp = write_en ? inc(waddr) : waddr;
  assign wfull_tmp = (inc(waddr_tmp) == raddr);

  always_comb begin
    next_state = NOT_FULL;
    if (wfull_tmp) begin
      next_state = FULL;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      current_state <= NOT_FULL;
      waddr         <= '0;
      waddr_gray    <= '0;
    end else begin
      current_state <= next_state;
      waddr         <= waddr_tmp;
      waddr_gray    <= waddr_tmp ^ (waddr_tmp >> 1);
    end
  end

  assign bus.wfull      = wfull;
  assign bus.write_en   = write_en;
  assign bus.waddr      = waddr;
  assign bus.waddr_gray = waddr_gray;

endmodule

// File: tb/tb_fifo_wr_logic.sv
// Scoreboard bench for fifo_wr_logic: directed scenarios then random traffic
// against an occupancy-level reference model.
module tb_fifo_wr_logic;

  localparam int unsigned DEPTH  = 3;
  localparam int unsigned PTR_SZ = 2;

  typedef struct {
    logic              we;
    logic [PTR_SZ-1:0] waddr;
    logic [PTR_SZ-1:0] gray;
    logic              full;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  fifo_wr_logic_if #(.PTR_SZ(PTR_SZ)) bus ();

  fifo_wr_logic #(.DEPTH(DEPTH), .PTR_SZ(PTR_SZ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state: write pointer, full flag, read pointer for random traffic
  int m_wptr = 0;
  bit m_full = 1'b0;
  int m_rptr = 0;

  function automatic int to_gray(input int b);
    return b ^ (b >> 1);
  endfunction

  function automatic int from_gray(input int g);
    for (int b = 0; b < (1 << PTR_SZ); b++) begin
      if (to_gray(b) == g) return b;
    end
    return 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: drive after the edge, predict outputs, advance model
  task automatic step(input bit r, input bit w, input int rq2);
    exp_t e;
    bit   we;
    @(posedge clk);
    #1;
    rst           = r;
    bus.winc      = w;
    bus.rq2_raddr = PTR_SZ'(rq2);
    we      = r && w && !m_full;
    e.we    = we;
    e.waddr = PTR_SZ'(m_wptr);
    e.gray  = PTR_SZ'(to_gray(m_wptr));
    e.full  = m_full;
    q.push_back(e);
    if (!r) begin
      m_wptr = 0;
      m_full = 1'b0;
    end else begin
      if (we) m_wptr = (m_wptr + 1) % DEPTH;
      m_full = (((m_wptr + 1) % DEPTH) == from_gray(rq2));
    end
  endtask

  // Monitor: mid-cycle, inputs are settled and registers show the last edge
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("write_en",   int'(bus.write_en),   int'(e.we));
      chk("waddr",      int'(bus.waddr),      int'(e.waddr));
      chk("waddr_gray", int'(bus.waddr_gray), int'(e.gray));
      chk("wfull",      int'(bus.wfull),      int'(e.full));
    end
  end

  initial begin
    rst           = 1'b0;
    bus.winc      = 1'b1;
    bus.rq2_raddr = '0;

    // reset with winc held high
    step(0, 1, 0);
    step(0, 1, 0);
    // fill to full, then overflow attempts
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 1, 0);
    // release and wrap
    step(1, 0, to_gray(1));
    step(1, 1, to_gray(1));
    step(1, 0, to_gray(1));
    // reach waddr=1 with raddr=0
    step(1, 0, to_gray(2));
    step(1, 1, to_gray(2));
    step(1, 0, to_gray(0));
    // write and read-pointer change in the same cycle
    step(1, 1, to_gray(1));
    step(1, 0, to_gray(1));
    // full at waddr=2, then mid-operation reset
    step(1, 0, to_gray(0));
    step(1, 0, to_gray(0));
    step(0, 1, to_gray(0));
    step(1, 1, to_gray(0));
    step(1, 0, to_gray(0));

    // random traffic: read pointer only advances over written data
    step(0, 0, 0);
    m_rptr = 0;
    for (int i = 0; i < 400; i++) begin
      bit r;
      r = ($urandom_range(0, 63) != 0);
      if (!r) begin
        m_rptr = 0;
      end else if ($urandom_range(0, 2) == 0 && m_rptr != m_wptr) begin
        m_rptr = (m_rptr + 1) % DEPTH;
      end
      step(r, bit'($urandom_range(0, 1)), to_gray(m_rptr));
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
